// File: rtl/alu_pkg.sv
// Shared opcodes for the 2-bit ALU and the command controller that drives it.
package alu_pkg;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_INC = 2'b11;

    localparam logic [2:0] CMD_MUL = 3'b100;
endpackage

// File: rtl/alu.sv
// Combinational 2-bit-opcode ALU (ADD/SUB/AND/INC); instantiated beside the controller.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [1:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] out_alu
);

    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    // Result selection; every operation wraps modulo 2^DATA_WIDTH.
    always_comb begin
        out_alu = {DATA_WIDTH{1'b0}};
        case (alu_op)
            ALU_ADD: out_alu = a + b;
            ALU_SUB: out_alu = a - b;
            ALU_AND: out_alu = a & b;
            ALU_INC: out_alu = a + ONE;
            default: out_alu = {DATA_WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command-side controller for the external ALU: one response per command,
// with MUL built from repeated ALU additions.
module alu_cmd_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    output logic [1:0]            alu_op,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_out,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err
);

    localparam logic [DATA_WIDTH-1:0] ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_MUL  = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    state_t                state_r, state_s;
    logic [DATA_WIDTH-1:0] a_r, a_s;
    logic [DATA_WIDTH-1:0] cnt_r, cnt_s;
    logic [1:0]            alu_op_s;
    logic [DATA_WIDTH-1:0] alu_a_s, alu_b_s;
    logic [DATA_WIDTH-1:0] rsp_data_s;
    logic                  rsp_err_s;
    logic                  cmd_ready_s, rsp_valid_s;

    // Next-state and next-output decode; ALU drive is precomputed so the
    // ALU inputs are registered yet valid throughout EXEC/MUL. In MUL,
    // alu_a doubles as the accumulator.
    always_comb begin
        state_s    = state_r;
        a_s        = a_r;
        cnt_s      = cnt_r;
        rsp_data_s = rsp_data;
        rsp_err_s  = rsp_err;
        alu_op_s   = ALU_ADD;
        alu_a_s    = ZERO;
        alu_b_s    = ZERO;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    a_s = cmd_a;
                    if (cmd_op[2] == 1'b0) begin
                        state_s  = ST_EXEC;
                        alu_op_s = cmd_op[1:0];
                        alu_a_s  = cmd_a;
                        alu_b_s  = cmd_b;
                    end else if (cmd_op == CMD_MUL) begin
                        if (cmd_b != ZERO) begin
                            state_s = ST_MUL;
                            cnt_s   = cmd_b;
                            alu_b_s = cmd_a;
                        end else begin
                            state_s    = ST_RESP;
                            rsp_data_s = ZERO;
                            rsp_err_s  = 1'b0;
                        end
                    end else begin
                        state_s    = ST_RESP;
                        rsp_data_s = ZERO;
                        rsp_err_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                rsp_data_s = alu_out;
                rsp_err_s  = 1'b0;
                state_s    = ST_RESP;
            end
            ST_MUL: begin
                cnt_s = cnt_r - ONE;
                if (cnt_r == ONE) begin
                    rsp_data_s = alu_out;
                    rsp_err_s  = 1'b0;
                    state_s    = ST_RESP;
                end else begin
                    alu_a_s = alu_out;
                    alu_b_s = a_r;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        cmd_ready_s = (state_s == ST_IDLE);
        rsp_valid_s = (state_s == ST_RESP);
    end

    // State and registered outputs; reset aborts any command in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            a_r       <= ZERO;
            cnt_r     <= ZERO;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= ZERO;
            rsp_err   <= 1'b0;
            alu_op    <= ALU_ADD;
            alu_a     <= ZERO;
            alu_b     <= ZERO;
        end else begin
            state_r   <= state_s;
            a_r       <= a_s;
            cnt_r     <= cnt_s;
            cmd_ready <= cmd_ready_s;
            rsp_valid <= rsp_valid_s;
            rsp_data  <= rsp_data_s;
            rsp_err   <= rsp_err_s;
            alu_op    <= alu_op_s;
            alu_a     <= alu_a_s;
            alu_b     <= alu_b_s;
        end
    end

endmodule
